fpu_issue_ctrl: RTL and testbench
=================================

Name: fpu_issue_ctrl

Overview:
- Initiator side of the FPU en/done handshake.
- Accepts one floating-point instruction from decode (ADDF, FTOI, ITOF, MULF, RECF, SUBF) with its operand values already read.
- Drives the fpu's en/instr/op1/op2, stalls decode until done, then writes the result back to the register file in one cycle.
- A watchdog flags FPU hangs and releases the pipeline.

Parameters:
- TIMEOUT, 32, max cycles in WAIT before abort; must be >= 2.
- TW, 6, watchdog counter width; 2^TW must exceed TIMEOUT.

Ports:
- clk  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high
- op_valid  in  1  decode presents an instruction this cycle
- op  in  5  opcode (OPxxx encoding)
- op_rd  in  4  destination register index
- rd_val  in  16  value of Rd (op1)
- rn_val  in  16  value of Rn or immediate (op2)
- stall  out  1  decode must hold its instruction
- fpu_en  out  1  FPU enable
- fpu_instr  out  5  opcode to FPU
- fpu_op1  out  16  FPU operand 1
- fpu_op2  out  16  FPU operand 2
- fpu_result  in  16  FPU result
- fpu_done  in  1  FPU completion flag
- wb_en  out  1  register-file write strobe
- wb_addr  out  4  register-file write index
- wb_data  out  16  register-file write data
- busy  out  1  an operation is in flight
- fpu_err  out  1  sticky timeout flag

Behaviour:
- Reset values: stall=0, fpu_en=0, fpu_instr=0, fpu_op1=0, fpu_op2=0, wb_en=0, wb_addr=0, wb_data=0, busy=0, fpu_err=0, state=IDLE, watchdog=0.
- Accepted ops: 0x11–0x16. Any other op with op_valid is ignored: no stall, no state change.
- States:
  - IDLE: if op_valid and op is accepted, latch op, op_rd, rd_val, rn_val into fpu_instr/wb_addr/fpu_op1/fpu_op2. Go to ISSUE; busy=1.
  - ISSUE (exactly 1 cycle): fpu_en=1. fpu_done is ignored this cycle because it may be stale from the previous op. Clear watchdog. Go to WAIT.
  - WAIT: fpu_en=1. Watchdog increments each cycle.
    - If fpu_done=1: capture fpu_result into wb_data, go to WB.
    - Else if watchdog == TIMEOUT-1: set fpu_err, wb_data=16'h0000, go to WB with wb suppressed.
  - WB (1 cycle): fpu_en=0. wb_en=1 unless the op was aborted. Go to IDLE; busy=0.
- stall:
  - Combinational: (state != IDLE) or (op_valid and accepted op in IDLE).
  - Decode therefore holds the instruction during the acceptance cycle and through WB. It advances on the cycle after WB, when stall=0.
- Latency: accept edge → ISSUE → WAIT (≥1 cycle) → WB. Minimum accept-to-wb_en is 3 cycles; wb_en is exactly one cycle wide.
- fpu_en is deasserted in IDLE and WB. This guarantees at least one disabled cycle between consecutive ops.
- Operands are latched at acceptance. Changes on rd_val/rn_val/op while busy are ignored.
- fpu_done seen in WAIT at the same edge the watchdog expires: done wins and the result is written.
- fpu_err is sticky until reset; later ops still execute normally.
- Reset asserted in any state: return to IDLE next edge with all outputs at reset values. No wb_en is issued for the aborted op.
- op_valid in WB: not accepted that cycle (stall=1); accepted in the following IDLE cycle.

Decomposition:
- Shared package/include holds: OP* opcode constants, WORD/DATA width macros, the FP field macros (SIGN/EXP/MANT), and the state encodings IDLE/ISSUE/WAIT/WB, following the existing FPU_* numeric-state style.
- Natural sub-module: fpu_watchdog (counter with clear, enable, expire output), sized by TW/TIMEOUT.
- The fpu itself is instantiated by the parent, not inside this block.

Test Plan:
- ITOF rn_val=0x0005, behavioural FPU with 3-cycle latency → fpu_op2=0x0005 during ISSUE; wb_en once, wb_data=0x40A0, wb_addr=op_rd; stall high for 6 cycles.
- MULF rd_val=0x4000, rn_val=0x4040; FPU holds done=1 from the previous op during ISSUE → stale done ignored; write occurs only after fresh done; wb_data=0x40C0.
- ITOF rn_val=0x0000 with FPU done=1 on the first WAIT cycle → minimum latency 3; wb_data=0x0000; stall released the cycle after WB.
- FPU never asserts done, TIMEOUT=8 → fpu_err=1 after 8 WAIT cycles; no wb_en; busy drops; next FTOI 0x40A0 completes with wb_data=0x0005 and fpu_err still 1.
- Non-FP op 0x08 (ADD) with op_valid → stall=0, fpu_en=0, no write. Reset asserted mid-WAIT → IDLE next edge, all outputs 0, no write.
- Back-to-back RECF then SUBF held on op_valid → fpu_en low for at least one cycle between them; both writes occur in order to their respective op_rd.

Source files
------------

// File: rtl/fpu_issue_ctrl_pkg.sv
// Shared definitions for the FPU issue controller: widths, opcodes,
// bfloat16 field positions and controller state encodings.
package fpu_issue_ctrl_pkg;

  localparam int WORD_W = 16;
  localparam int DATA_W = 16;
  localparam int OP_W   = 5;
  localparam int REG_W  = 4;

  // Operands are bfloat16: 1 sign, 8 exponent, 7 mantissa bits.
  localparam int FP_SIGN_BIT = 15;
  localparam int FP_EXP_HI   = 14;
  localparam int FP_EXP_LO   = 7;
  localparam int FP_MANT_HI  = 6;
  localparam int FP_MANT_LO  = 0;

  localparam logic [OP_W-1:0] OPADD  = 5'h08;
  localparam logic [OP_W-1:0] OPADDF = 5'h11;
  localparam logic [OP_W-1:0] OPFTOI = 5'h12;
  localparam logic [OP_W-1:0] OPITOF = 5'h13;
  localparam logic [OP_W-1:0] OPMULF = 5'h14;
  localparam logic [OP_W-1:0] OPRECF = 5'h15;
  localparam logic [OP_W-1:0] OPSUBF = 5'h16;

  typedef enum logic [1:0] {
    FPU_IDLE  = 2'd0,
    FPU_ISSUE = 2'd1,
    FPU_WAIT  = 2'd2,
    FPU_WB    = 2'd3
  } fpu_state_e;

  function automatic logic is_fp_op(input logic [OP_W-1:0] op);
    return (op >= OPADDF) && (op <= OPSUBF);
  endfunction

endpackage

// File: rtl/fpu_issue_ctrl_watchdog.sv
// Cycle counter for the FPU wait phase; o_expire is high while the count
// sits at TIMEOUT-1, i.e. on the last cycle the controller may keep waiting.
module fpu_watchdog #(
  parameter int TIMEOUT = 32,
  parameter int TW      = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_count;
  logic          w_expire;

  assign w_expire = (r_count == LIMIT);
  assign o_expire = w_expire;

  // Saturates at the limit so a stray extra enable cannot wrap the count.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_count <= '0;
    end else if (i_en && !w_expire) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Initiator side of the FPU en/done handshake: accepts one FP instruction,
// holds decode while the FPU works, then writes the result back in one cycle.
module fpu_issue_ctrl
  import fpu_issue_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 32,
  parameter int TW      = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              op_valid,
  input  logic [OP_W-1:0]   op,
  input  logic [REG_W-1:0]  op_rd,
  input  logic [WORD_W-1:0] rd_val,
  input  logic [WORD_W-1:0] rn_val,
  output logic              stall,
  output logic              fpu_en,
  output logic [OP_W-1:0]   fpu_instr,
  output logic [WORD_W-1:0] fpu_op1,
  output logic [WORD_W-1:0] fpu_op2,
  input  logic [DATA_W-1:0] fpu_result,
  input  logic              fpu_done,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              busy,
  output logic              fpu_err,
  output fpu_state_e        dbg_state
);

  // Handshake: decode presents op_valid with an instruction and must hold it
  // for every cycle stall is high; the instruction is consumed on the first
  // cycle after WB. The FPU sees fpu_en high from ISSUE through WAIT and
  // answers with a fpu_done pulse/level; done is only trusted in WAIT.

  fpu_state_e        r_state;
  logic              r_fpu_en;
  logic [OP_W-1:0]   r_fpu_instr;
  logic [WORD_W-1:0] r_fpu_op1;
  logic [WORD_W-1:0] r_fpu_op2;
  logic              r_wb_en;
  logic [REG_W-1:0]  r_wb_addr;
  logic [DATA_W-1:0] r_wb_data;
  logic              r_busy;
  logic              r_fpu_err;

  logic w_accept;
  logic w_wd_clr;
  logic w_wd_en;
  logic w_wd_expire;

  assign w_accept = (r_state == FPU_IDLE) && op_valid && is_fp_op(op);
  assign w_wd_clr = (r_state == FPU_ISSUE);
  assign w_wd_en  = (r_state == FPU_WAIT);

  fpu_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_watchdog (
    .clk      (clk),
    .reset    (reset),
    .i_clr    (w_wd_clr),
    .i_en     (w_wd_en),
    .o_expire (w_wd_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= FPU_IDLE;
      r_fpu_en    <= 1'b0;
      r_fpu_instr <= '0;
      r_fpu_op1   <= '0;
      r_fpu_op2   <= '0;
      r_wb_en     <= 1'b0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_busy      <= 1'b0;
      r_fpu_err   <= 1'b0;
    end else begin
      r_wb_en <= 1'b0;
      case (r_state)
        FPU_IDLE: begin
          if (w_accept) begin
            r_fpu_instr <= op;
            r_wb_addr   <= op_rd;
            r_fpu_op1   <= rd_val;
            r_fpu_op2   <= rn_val;
            r_fpu_en    <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= FPU_ISSUE;
          end
        end
        // fpu_done may still be high from the previous op here, so skip it.
        FPU_ISSUE: begin
          r_state <= FPU_WAIT;
        end
        FPU_WAIT: begin
          if (fpu_done) begin
            r_wb_data <= fpu_result;
            r_wb_en   <= 1'b1;
            r_fpu_en  <= 1'b0;
            r_state   <= FPU_WB;
          end else if (w_wd_expire) begin
            r_fpu_err <= 1'b1;
            r_wb_data <= '0;
            r_fpu_en  <= 1'b0;
            r_state   <= FPU_WB;
          end
        end
        FPU_WB: begin
          r_busy  <= 1'b0;
          r_state <= FPU_IDLE;
        end
        default: begin
          r_state <= FPU_IDLE;
        end
      endcase
    end
  end

  assign stall     = (r_state != FPU_IDLE) || w_accept;
  assign fpu_en    = r_fpu_en;
  assign fpu_instr = r_fpu_instr;
  assign fpu_op1   = r_fpu_op1;
  assign fpu_op2   = r_fpu_op2;
  assign wb_en     = r_wb_en;
  assign wb_addr   = r_wb_addr;
  assign wb_data   = r_wb_data;
  assign busy      = r_busy;
  assign fpu_err   = r_fpu_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Bench for fpu_issue_ctrl: a latency-programmable FPU model, a decode-side
// driver, and a write-back scoreboard fed from per-instruction expectations.
module tb_fpu_issue_ctrl;
  import fpu_issue_ctrl_pkg::*;

  localparam int TIMEOUT = 8;
  localparam int TW      = 4;
  localparam int BUDGET  = TIMEOUT + 12;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [4:0]  op = '0;
  logic [3:0]  op_rd = '0;
  logic [15:0] rd_val = '0;
  logic [15:0] rn_val = '0;
  logic [15:0] fpu_result = '0;
  logic        fpu_done = 1'b0;

  logic        stall, fpu_en, wb_en, busy, fpu_err;
  logic [4:0]  fpu_instr;
  logic [15:0] fpu_op1, fpu_op2, wb_data;
  logic [3:0]  wb_addr;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  fpu_issue_ctrl #(.TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .clk        (clk),
    .reset      (reset),
    .op_valid   (op_valid),
    .op         (op),
    .op_rd      (op_rd),
    .rd_val     (rd_val),
    .rn_val     (rn_val),
    .stall      (stall),
    .fpu_en     (fpu_en),
    .fpu_instr  (fpu_instr),
    .fpu_op1    (fpu_op1),
    .fpu_op2    (fpu_op2),
    .fpu_result (fpu_result),
    .fpu_done   (fpu_done),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .busy       (busy),
    .fpu_err    (fpu_err),
    .dbg_state  (dbg_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- FPU model ----------------
  // fm_lat = number of WAIT cycles before done is seen (0 = never answers).
  // fm_stale keeps done high while disabled and through the first enabled cycle.
  int          fm_lat = 0;
  logic [15:0] fm_res = '0;
  bit          fm_stale = 1'b0;
  int          fm_cnt = 0;

  always @(negedge clk) begin
    if (fpu_en) begin
      fm_cnt++;
      if (fm_cnt == 1) begin
        fpu_done   = fm_stale;
        fpu_result = 16'hDEAD;
      end else begin
        fpu_done   = (fm_lat != 0) && (fm_cnt - 1 >= fm_lat);
        fpu_result = fpu_done ? fm_res : 16'hBEEF;
      end
    end else begin
      fm_cnt     = 0;
      fpu_done   = fm_stale;
      fpu_result = 16'hDEAD;
    end
  end

  // ---------------- scoreboard ----------------
  logic [19:0] exp_q[$];
  int   n_wb = 0;
  int   n_exp_wb = 0;
  int   n_en_rise = 0;
  int   n_accepted = 0;
  logic prev_en = 1'b0;
  bit   err_model = 1'b0;

  always @(negedge clk) begin
    if (fpu_en && !prev_en) n_en_rise++;
    prev_en = fpu_en;
    if (wb_en) begin
      n_wb++;
      check("wb_expected", {31'd0, wb_en}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) check("wb_addr_data", {12'd0, wb_addr, wb_data}, {12'd0, exp_q.pop_front()});
    end
  end

  // ---------------- driver ----------------
  typedef struct {
    logic [4:0]  op;
    logic [3:0]  rd;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] res;
    int          lat;
    bit          stale;
  } op_t;

  op_t pend_q[$];

  task automatic present(input op_t t);
    op_valid = 1'b1;
    op       = t.op;
    op_rd    = t.rd;
    rd_val   = t.a;
    rn_val   = t.b;
    fm_lat   = t.lat;
    fm_res   = t.res;
    fm_stale = t.stale;
    #1;
  endtask

  // Follows one accepted instruction until its WB cycle; returns in WB.
  task automatic exec(input op_t t, input bit in_wb);
    bit wr;
    int w;
    int n_stall = 0;
    bit seen = 1'b0;
    bit fin = 1'b0;
    wr = (t.lat >= 1) && (t.lat <= TIMEOUT);
    w  = wr ? t.lat : TIMEOUT;
    if (wr) begin
      exp_q.push_back({t.rd, t.res});
      n_exp_wb++;
    end else begin
      err_model = 1'b1;
    end
    n_accepted++;
    for (int c = 0; c < BUDGET && !fin; c++) begin
      if (stall) n_stall++;
      if (!seen && busy && fpu_en) begin
        seen = 1'b1;
        check("issue_instr", {27'd0, fpu_instr}, {27'd0, t.op});
        check("issue_op1", {16'd0, fpu_op1}, {16'd0, t.a});
        check("issue_op2", {16'd0, fpu_op2}, {16'd0, t.b});
        rd_val = 16'($urandom_range(0, 65535));
        rn_val = 16'($urandom_range(0, 65535));
        op     = 5'($urandom_range(0, 31));
        op_rd  = 4'($urandom_range(0, 15));
      end else if (seen && busy && fpu_en) begin
        check("wait_op1_held", {16'd0, fpu_op1}, {16'd0, t.a});
        check("wait_op2_held", {16'd0, fpu_op2}, {16'd0, t.b});
      end else if (seen && busy && !fpu_en) begin
        fin = 1'b1;
        check("wb_en", {31'd0, wb_en}, {31'd0, wr});
        if (wr) check("wb_addr", {28'd0, wb_addr}, {28'd0, t.rd});
        check("wb_data", {16'd0, wb_data}, {16'd0, wr ? t.res : 16'h0000});
        check("fpu_err", {31'd0, fpu_err}, {31'd0, err_model});
      end
      if (!fin) begin
        @(negedge clk);
        #1;
      end
    end
    check("op_complete", {31'd0, fin}, 32'd1);
    check("stall_cycles", n_stall, w + 3 + (in_wb ? 1 : 0));
  endtask

  // Runs the queued instructions back to back, each presented during the
  // previous one's WB cycle, then lets decode go idle.
  task automatic run_pending();
    op_t t;
    bit  in_wb = 1'b0;
    while (pend_q.size() != 0) begin
      t = pend_q.pop_front();
      present(t);
      exec(t, in_wb);
      in_wb = 1'b1;
    end
    op_valid = 1'b0;
    @(negedge clk);
    #1;
    check("idle_stall", {31'd0, stall}, 32'd0);
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_fpu_en", {31'd0, fpu_en}, 32'd0);
  endtask

  task automatic push_op(input logic [4:0] o, input logic [3:0] rd, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] res, input int lat, input bit stale);
    op_t t;
    t.op = o; t.rd = rd; t.a = a; t.b = b; t.res = res; t.lat = lat; t.stale = stale;
    pend_q.push_back(t);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_stall"}, {31'd0, stall}, 32'd0);
    check({tag, "_fpu_en"}, {31'd0, fpu_en}, 32'd0);
    check({tag, "_instr_ops"}, {fpu_instr, fpu_op1, fpu_op2}, 37'd0);
    check({tag, "_wb"}, {11'd0, wb_en, wb_addr, wb_data}, 32'd0);
    check({tag, "_busy_err"}, {30'd0, busy, fpu_err}, 32'd0);
    check({tag, "_state"}, {30'd0, dbg_state}, {30'd0, FPU_IDLE});
  endtask

  // ---------------- stimulus ----------------
  logic [4:0] bad_ops[3];
  op_t        rst_op;
  int         n_wait;
  int         nb;

  initial begin
    bad_ops[0] = OPADD;
    bad_ops[1] = 5'h10;
    bad_ops[2] = 5'h17;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);
    #1;

    // ITOF 5 -> 5.0, three WAIT cycles
    push_op(OPITOF, 4'd3, 16'h0000, 16'h0005, 16'h40A0, 3, 1'b0);
    run_pending();
    // MULF 2.0*3.0 with done still high from the previous op
    push_op(OPMULF, 4'd7, 16'h4000, 16'h4040, 16'h40C0, 2, 1'b1);
    run_pending();
    // ITOF 0, done on the first WAIT cycle
    push_op(OPITOF, 4'd1, 16'h0000, 16'h0000, 16'h0000, 1, 1'b0);
    run_pending();
    // FPU never answers, then a normal FTOI with the error still flagged
    push_op(OPADDF, 4'd9, 16'h1234, 16'h5678, 16'hAAAA, 0, 1'b0);
    run_pending();
    push_op(OPFTOI, 4'd4, 16'h0000, 16'h40A0, 16'h0005, 2, 1'b0);
    run_pending();

    // Non-FP opcodes on both sides of the accepted range are ignored
    foreach (bad_ops[i]) begin
      op_valid = 1'b1;
      op       = bad_ops[i];
      #1;
      check("badop_stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      #1;
      check("badop_fpu_en", {31'd0, fpu_en}, 32'd0);
      check("badop_busy", {31'd0, busy}, 32'd0);
      op_valid = 1'b0;
    end

    // Reset in the middle of WAIT: no write, everything back to zero
    rst_op.op = OPSUBF; rst_op.rd = 4'd5; rst_op.a = 16'h1111; rst_op.b = 16'h2222;
    rst_op.res = 16'h3333; rst_op.lat = 0; rst_op.stale = 1'b0;
    present(rst_op);
    n_accepted++;
    n_wait = 0;
    for (int c = 0; c < BUDGET && n_wait < 3; c++) begin
      @(negedge clk);
      #1;
      if (busy && fpu_en) n_wait++;
    end
    check("rst_reached_wait", n_wait, 3);
    reset    = 1'b1;
    op_valid = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs("midreset");
    reset     = 1'b0;
    err_model = 1'b0;
    @(negedge clk);
    #1;

    // Back-to-back RECF then SUBF
    push_op(OPRECF, 4'd2, 16'h4000, 16'h4000, 16'h3F00, 2, 1'b0);
    push_op(OPSUBF, 4'd6, 16'h4040, 16'h4000, 16'h3F80, 1, 1'b1);
    run_pending();

    // Done arriving on the expiry cycle wins; one cycle later is too late
    push_op(OPADDF, 4'd8, 16'h3F80, 16'h3F80, 16'h4000, TIMEOUT, 1'b0);
    push_op(OPMULF, 4'd10, 16'h4000, 16'h4000, 16'h4080, TIMEOUT + 1, 1'b0);
    run_pending();

    // Randomized chains of accepted instructions
    for (int b = 0; b < 12; b++) begin
      nb = $urandom_range(1, 4);
      for (int k = 0; k < nb; k++) begin
        push_op(5'($urandom_range(32'(OPADDF), 32'(OPSUBF))),
                4'($urandom_range(0, 15)),
                16'($urandom_range(0, 65535)),
                16'($urandom_range(0, 65535)),
                16'($urandom_range(0, 65535)),
                $urandom_range(0, TIMEOUT + 2),
                1'($urandom_range(0, 1)));
      end
      run_pending();
    end

    repeat (2) @(negedge clk);
    check("sb_queue_empty", exp_q.size(), 0);
    check("wb_count", n_wb, n_exp_wb);
    check("en_rises", n_en_rise, n_accepted);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
